ri_pixel_writer: RTL

- Downstream of the range-image coordinate generator; consumes its per-point write address, range and angle-valid flag.
- Builds the range-image frame in an external single-port-read/single-port-write BRAM via read-modify-write, keeping the nearest (minimum non-zero) range per pixel.
- Clears the frame buffer between frames by a sequential sweep and reports per-frame point/drop statistics.

---
 rtl/ri_pkg.sv | 25 ++
 rtl/ri_fwd_cmp.sv | 38 +++
 rtl/ri_pixel_writer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ri_pkg.sv
// Shared definitions for the range-image blocks: default widths, the empty
// pixel value, the writer FSM states and a saturating counter increment.
package ri_pkg;

  localparam int RI_ADDR_W = 19;
  localparam int RI_DATA_W = 16;

  // A stored range of zero means "no return yet" for that pixel.
  localparam logic [RI_DATA_W-1:0] RI_EMPTY = '0;

  typedef enum logic [1:0] {
    ST_CLEAR     = 2'd0,
    ST_RUN       = 2'd1,
    ST_DRAIN_END = 2'd2,
    ST_DRAIN_CLR = 2'd3
  } ri_state_e;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] mx;
    mx = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= mx) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ri_fwd_cmp.sv
// Forwarding mux and nearest-range compare for the pixel read-modify-write.
// Purely combinational: picks the freshest stored value, then keeps the minimum non-zero.
module ri_fwd_cmp
  import ri_pkg::*;
#(
  parameter int ADDR_W = RI_ADDR_W,
  parameter int DATA_W = RI_DATA_W
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] range_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              s2_vld_i,
  input  logic [ADDR_W-1:0] s2_addr_i,
  input  logic [DATA_W-1:0] s2_data_i,
  input  logic              w3_vld_i,
  input  logic [ADDR_W-1:0] w3_addr_i,
  input  logic [DATA_W-1:0] w3_data_i,
  output logic [DATA_W-1:0] eff_o,
  output logic [DATA_W-1:0] new_o,
  output logic              wr_o
);

  logic [DATA_W-1:0] eff;

  // S2 is younger than W3, so it wins when both hit the same pixel.
  always_comb begin
    eff = rdata_i;
    if (s2_vld_i && (s2_addr_i == addr_i))
      eff = s2_data_i;
    else if (w3_vld_i && (w3_addr_i == addr_i))
      eff = w3_data_i;
  end

  assign eff_o = eff;
  assign new_o = ((eff == DATA_W'(RI_EMPTY)) || (range_i < eff)) ? range_i : eff;
  assign wr_o  = (new_o != eff);

endmodule

// File: rtl/ri_pixel_writer.sv
// Range-image frame builder: read-modify-write of the nearest range per pixel
// into an external BRAM, with a sequential clear sweep and per-frame statistics.
module ri_pixel_writer
  import ri_pkg::*;
#(
  parameter int          ADDR_W   = RI_ADDR_W,
  parameter int          DATA_W   = RI_DATA_W,
  parameter int unsigned MAX_ADDR = 524287,
  parameter int          CNT_W    = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_validAngle,
  input  logic [ADDR_W-1:0] i_wAddress,
  input  logic [DATA_W-1:0] i_range,
  input  logic              i_frameStart,
  input  logic              i_frameEnd,
  output logic              o_frameDone,
  output logic              o_clearBusy,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [CNT_W-1:0]  o_pointCount,
  output logic [CNT_W-1:0]  o_dropCount
);

  localparam int STAGES = 2;

  ri_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              pend_q, pend_d;
  logic              done_q, done_d;
  logic [STAGES:0]   vld_pipe_q, vld_pipe_d;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [DATA_W-1:0] s1_range_q;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] w3_addr_q;
  logic [DATA_W-1:0] w3_data_q;
  logic [CNT_W-1:0]  point_q, point_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic              accept, in_range, pt_ok, pt_drop, pipe_empty;
  logic [DATA_W-1:0] fwd_eff, fwd_new;
  logic              fwd_wr;

  assign o_ready     = (state_q == ST_RUN);
  assign o_clearBusy = (state_q == ST_CLEAR);
  assign mem_raddr   = i_wAddress;
  assign mem_we      = we_q;
  assign mem_waddr   = waddr_q;
  assign mem_wdata   = wdata_q;
  assign o_frameDone = done_q;
  assign o_pointCount = point_q;
  assign o_dropCount  = drop_q;

  assign accept     = i_valid && o_ready;
  assign in_range   = (32'(i_wAddress) <= MAX_ADDR);
  assign pt_ok      = accept && i_validAngle && (i_range != DATA_W'(RI_EMPTY)) && in_range;
  assign pt_drop    = accept && !pt_ok;
  assign pipe_empty = !vld_pipe_q[0] && !vld_pipe_q[1];

  // S2 lives in the write register itself; W3 is that register one cycle later.
  ri_fwd_cmp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd (
    .addr_i    (s1_addr_q),
    .range_i   (s1_range_q),
    .rdata_i   (mem_rdata),
    .s2_vld_i  (vld_pipe_q[1]),
    .s2_addr_i (waddr_q),
    .s2_data_i (wdata_q),
    .w3_vld_i  (vld_pipe_q[2]),
    .w3_addr_i (w3_addr_q),
    .w3_data_i (w3_data_q),
    .eff_o     (fwd_eff),
    .new_o     (fwd_new),
    .wr_o      (fwd_wr)
  );

  // W3 also tracks the final clear write, which lands while RUN has already begun.
  assign vld_pipe_d = {vld_pipe_q[1] | we_q, vld_pipe_q[0], pt_ok};

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    pend_d     = pend_q;
    done_d     = 1'b0;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    point_d    = point_q;
    drop_d     = drop_q;

    if (vld_pipe_q[0]) begin
      we_d    = fwd_wr;
      waddr_d = s1_addr_q;
      wdata_d = fwd_new;
      if (fwd_wr)
        point_d = CNT_W'(sat_inc(32'(point_q), CNT_W));
    end
    if (pt_drop)
      drop_d = CNT_W'(sat_inc(32'(drop_q), CNT_W));

    case (state_q)
      ST_CLEAR: begin
        we_d    = 1'b1;
        waddr_d = clr_addr_q;
        wdata_d = DATA_W'(RI_EMPTY);
        if (i_frameStart) begin
          clr_addr_d = '0;
          point_d    = '0;
          drop_d     = '0;
        end else if (clr_addr_q == ADDR_W'(MAX_ADDR)) begin
          clr_addr_d = '0;
          state_d    = ST_RUN;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (i_frameEnd) begin
          state_d = ST_DRAIN_END;
          pend_d  = i_frameStart;
        end else if (i_frameStart) begin
          state_d = ST_DRAIN_CLR;
        end
      end
      ST_DRAIN_END: begin
        if (i_frameStart)
          pend_d = 1'b1;
        if (pipe_empty) begin
          done_d  = 1'b1;
          state_d = (pend_q || i_frameStart) ? ST_DRAIN_CLR : ST_RUN;
          pend_d  = 1'b0;
        end
      end
      ST_DRAIN_CLR: begin
        if (pipe_empty) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
          point_d    = '0;
          drop_d     = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      pend_q     <= 1'b0;
      done_q     <= 1'b0;
      vld_pipe_q <= '0;
      s1_addr_q  <= '0;
      s1_range_q <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      w3_addr_q  <= '0;
      w3_data_q  <= '0;
      point_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      pend_q     <= pend_d;
      done_q     <= done_d;
      vld_pipe_q <= vld_pipe_d;
      s1_addr_q  <= i_wAddress;
      s1_range_q <= i_range;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      w3_addr_q  <= waddr_q;
      w3_data_q  <= wdata_q;
      point_q    <= point_d;
      drop_q     <= drop_d;
    end
  end

endmodule
